// File: rtl/note_gen_pkg.sv
// note_gen_pkg: shared constants, divider state type and volume helper for
// the note_gen square-wave tone generator.
//   SIL_TONE   - explicit silence code from the tone lookup stage
//   DIV_CYCLES - quotient bits produced by the sequential divider
//   MAX_VOL    - highest distinct volume level; larger codes saturate
package note_gen_pkg;

    localparam logic [31:0] SIL_TONE   = 32'd50_000_000;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned MAX_VOL    = 5;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } div_state_t;

    // Left-shift applied to the base amplitude; volume 0 is handled by the caller.
    function automatic logic [2:0] vol_shift(input logic [2:0] volume);
        if (volume >= 3'(MAX_VOL)) begin
            return 3'(MAX_VOL - 1);
        end else if (volume == 3'd0) begin
            return 3'd0;
        end else begin
            return volume - 3'd1;
        end
    endfunction

endpackage

// File: rtl/note_channel.sv
// note_channel: one audio channel. Latches a tone frequency, converts it to a
// half-period cycle count with a 32-step restoring divider, and drives a
// square wave whose amplitude follows the volume setting.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - playback enable; low forces the sample and counters to 0
//   volume     - 0 mute, 1..5 level, 6..7 saturate to 5
//   tone       - tone frequency in Hz (0, > MAX_TONE_HZ or SIL_TONE = silent)
//   sample     - signed 16-bit sample, registered
module note_channel
    import note_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned MAX_TONE_HZ = 20_000,
    parameter logic [15:0] BASE_AMP    = 16'h0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  volume,
    input  logic [31:0] tone,
    output logic [15:0] sample
);

    localparam logic [31:0]       DIVIDEND  = 32'(CLK_HZ / 2);
    localparam int unsigned       ITER_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIV_CYCLES);

    div_state_t        state;
    logic [31:0]       tone_q;
    logic [31:0]       half_period;
    logic [31:0]       cnt;
    logic              phase;
    logic [31:0]       rem;
    logic [31:0]       dvd;
    logic [31:0]       quot;
    logic [ITER_W-1:0] iter;

    logic              busy;
    logic              tone_change;
    logic              tone_silent;
    logic              div_done;
    logic              clear_run;
    logic              active;
    logic [32:0]       rem_shift;
    logic [32:0]       rem_trial;
    logic              q_bit;
    logic [15:0]       amp;
    logic [15:0]       neg_amp;

    // Restoring-divide step and control decodes.
    always_comb begin
        busy        = (state == DIV);
        tone_change = (tone != tone_q);
        tone_silent = (tone == 32'd0) || (tone > 32'(MAX_TONE_HZ)) || (tone == SIL_TONE);
        div_done    = busy && (iter == LAST_ITER);
        // A new half-period (loaded or silenced) restarts the waveform at phase 0.
        clear_run   = div_done || (!busy && tone_change && tone_silent);
        active      = en && (half_period != 32'd0);
        rem_shift   = {rem, dvd[31]};
        rem_trial   = rem_shift - {1'b0, tone_q};
        // No borrow out of the trial subtraction means the divisor fits.
        q_bit       = ~rem_trial[32];
        amp         = (volume == 3'd0) ? 16'd0 : 16'(BASE_AMP << vol_shift(volume));
        neg_amp     = 16'd0 - amp;
    end

    // Tone latch and divider FSM; a divide in flight always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tone_q      <= '0;
            half_period <= '0;
            rem         <= '0;
            dvd         <= '0;
            quot        <= '0;
            iter        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tone_change) begin
                        tone_q <= tone;
                        if (tone_silent) begin
                            half_period <= '0;
                        end else begin
                            state <= DIV;
                            rem   <= '0;
                            dvd   <= DIVIDEND;
                            quot  <= '0;
                            iter  <= '0;
                        end
                    end
                end
                DIV: begin
                    if (iter == LAST_ITER) begin
                        half_period <= quot;
                        state       <= IDLE;
                    end else begin
                        rem  <= q_bit ? rem_trial[31:0] : rem_shift[31:0];
                        dvd  <= {dvd[30:0], 1'b0};
                        quot <= {quot[30:0], q_bit};
                        iter <= iter + ITER_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Free-running toggle counter and registered sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            phase  <= 1'b0;
            sample <= '0;
        end else begin
            sample <= active ? (phase ? amp : neg_amp) : 16'd0;
            if (!active || clear_run) begin
                cnt   <= '0;
                phase <= 1'b0;
            end else if (cnt == half_period - 32'd1) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/note_gen.sv
// note_gen: stereo square-wave tone generator fed by the beat-to-tone stage.
// Build option: NOTE_GEN_MONO_EN - only the left channel is built, toneR is
// ignored and audio_right mirrors audio_left.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   en                   - playback enable
//   volume               - 0 mute, 1..5 level, 6..7 saturate to 5
//   toneL, toneR         - per-channel tone frequency in Hz
//   audio_left/right     - signed 16-bit samples, registered
module note_gen #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned MAX_TONE_HZ = 20_000,
    parameter logic [15:0] BASE_AMP    = 16'h0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [2:0]  volume,
    input  logic [31:0] toneL,
    input  logic [31:0] toneR,
    output logic [15:0] audio_left,
    output logic [15:0] audio_right
);

    note_channel #(
        .CLK_HZ      (CLK_HZ),
        .MAX_TONE_HZ (MAX_TONE_HZ),
        .BASE_AMP    (BASE_AMP)
    ) u_left (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .volume (volume),
        .tone   (toneL),
        .sample (audio_left)
    );

`ifdef NOTE_GEN_MONO_EN
    // Right output shares the left sample register.
    logic unused_tone_r;
    assign unused_tone_r = ^toneR;
    assign audio_right   = audio_left;
`else
    note_channel #(
        .CLK_HZ      (CLK_HZ),
        .MAX_TONE_HZ (MAX_TONE_HZ),
        .BASE_AMP    (BASE_AMP)
    ) u_right (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .volume (volume),
        .tone   (toneR),
        .sample (audio_right)
    );
`endif

endmodule

// File: tb/tb_note_gen.sv
// tb_note_gen: self-checking bench for note_gen. A frequency-level reference
// model (half period = (CLK_HZ/2)/tone, waveform phase from elapsed cycles)
// predicts both samples every cycle; directed tasks add spot checks.
module tb_note_gen;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned MAX_TONE_HZ = 20_000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  volume = 3'd0;
    logic [31:0] toneL = 32'd0;
    logic [31:0] toneR = 32'd0;
    logic [15:0] audio_left;
    logic [15:0] audio_right;

    int checks   = 0;
    int failures = 0;

    note_gen #(
        .CLK_HZ      (CLK_HZ),
        .MAX_TONE_HZ (MAX_TONE_HZ),
        .BASE_AMP    (16'h0400)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .volume      (volume),
        .toneL       (toneL),
        .toneR       (toneR),
        .audio_left  (audio_left),
        .audio_right (audio_right)
    );

    always #5 clk = ~clk;

    // Reference model state, indexed by channel (0 left, 1 right).
    longint unsigned m_k;
    logic [31:0]     m_tq      [2];
    bit              m_busy    [2];
    longint unsigned m_load_at [2];
    longint unsigned m_pend    [2];
    longint unsigned m_hp      [2];
    longint unsigned m_c       [2];
    logic [15:0]     m_exp     [2];

    function automatic int amp_of(input logic [2:0] v);
        int lvl;
        lvl = (v > 3'd5) ? 5 : int'(v);
        return (lvl == 0) ? 0 : ('h400 << (lvl - 1));
    endfunction

    function automatic logic [15:0] exp_right();
`ifdef NOTE_GEN_MONO_EN
        return m_exp[0];
`else
        return m_exp[1];
`endif
    endfunction

    task automatic model_reset();
        m_k = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_tq[ch] = 32'd0; m_busy[ch] = 1'b0; m_load_at[ch] = 0;
            m_pend[ch] = 0; m_hp[ch] = 0; m_c[ch] = 0; m_exp[ch] = 16'd0;
        end
    endtask

    // One clock edge of the model, using the inputs seen at that edge.
    task automatic model_step(input int ch, input logic [31:0] t);
        int a;
        longint unsigned ph;
        a = amp_of(volume);
        if (en && m_hp[ch] != 0) begin
            ph = ((m_k - 1 - m_c[ch]) / m_hp[ch]) % 2;
            m_exp[ch] = (ph == 1) ? 16'(a) : 16'(-a);
        end else begin
            m_exp[ch] = 16'd0;
            m_c[ch]   = m_k;
        end
        if (m_busy[ch] && m_k == m_load_at[ch]) begin
            m_hp[ch] = m_pend[ch]; m_c[ch] = m_k; m_busy[ch] = 1'b0;
        end else if (!m_busy[ch] && t != m_tq[ch]) begin
            m_tq[ch] = t;
            if (t == 0 || t > MAX_TONE_HZ || t == 32'd50_000_000) begin
                m_hp[ch] = 0; m_c[ch] = m_k;
            end else begin
                m_busy[ch] = 1'b1;
                m_pend[ch] = longint'(CLK_HZ / 2) / longint'(t);
                m_load_at[ch] = m_k + 33;
            end
        end
    endtask

    // Advance one clock and leave the caller at the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_k = m_k + 1;
            model_step(0, toneL);
            model_step(1, toneR);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (audio_left !== 16'd0) begin failures++; $display("FAIL reset_left: got %h expected 0000", audio_left); end
        checks++;
        if (audio_right !== 16'd0) begin failures++; $display("FAIL reset_right: got %h expected 0000", audio_right); end
        checks++;
        if (dut.u_left.half_period !== 32'd0) begin failures++; $display("FAIL reset_hp: got %0d expected 0", dut.u_left.half_period); end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL post_reset_left: got %h expected %h", audio_left, m_exp[0]); end
        end
    endtask

    task automatic test_tone_988();
        en = 1'b1; volume = 3'd3; toneL = 32'd988;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL t988_left cyc %0d: got %h expected %h", i, audio_left, m_exp[0]); end
            checks++;
            if (audio_right !== exp_right()) begin failures++; $display("FAIL t988_right cyc %0d: got %h expected %h", i, audio_right, exp_right()); end
            if (i == 33) begin
                checks++;
                if (dut.u_left.half_period !== 32'd0) begin failures++; $display("FAIL t988_hp_early: got %0d expected 0", dut.u_left.half_period); end
            end
            if (i == 34) begin
                checks++;
                if (dut.u_left.half_period !== 32'd50607) begin failures++; $display("FAIL t988_hp: got %0d expected 50607", dut.u_left.half_period); end
            end
            if (i == 35) begin
                checks++;
                if (audio_left !== 16'hF000) begin failures++; $display("FAIL t988_amp: got %h expected f000", audio_left); end
            end
        end
    endtask

    task automatic test_volume_sat();
        volume = 3'd7; toneR = 32'd262;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL vsat_left cyc %0d: got %h expected %h", i, audio_left, m_exp[0]); end
            checks++;
            if (audio_right !== exp_right()) begin failures++; $display("FAIL vsat_right cyc %0d: got %h expected %h", i, audio_right, exp_right()); end
`ifndef NOTE_GEN_MONO_EN
            if (i == 34) begin
                checks++;
                if (dut.u_right.half_period !== 32'd190839) begin failures++; $display("FAIL t262_hp: got %0d expected 190839", dut.u_right.half_period); end
            end
`endif
            if (i == 35) begin
                checks++;
                if (audio_right !== 16'hC000) begin failures++; $display("FAIL vol7_right: got %h expected c000", audio_right); end
                checks++;
                if (audio_left !== 16'hC000) begin failures++; $display("FAIL vol7_left: got %h expected c000", audio_left); end
            end
        end
        volume = 3'd5;
        tick();
        checks++;
        if (audio_left !== 16'hC000) begin failures++; $display("FAIL vol5_left: got %h expected c000", audio_left); end
    endtask

    task automatic test_silence();
        toneL = 32'd50_000_000;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL sil_left cyc %0d: got %h expected %h", i, audio_left, m_exp[0]); end
            if (i == 1) begin
                checks++;
                if (dut.u_left.half_period !== 32'd0) begin failures++; $display("FAIL sil_hp: got %0d expected 0", dut.u_left.half_period); end
            end
            if (i == 2) begin
                checks++;
                if (audio_left !== 16'd0) begin failures++; $display("FAIL sil_out: got %h expected 0000", audio_left); end
            end
        end
        toneL = 32'd660;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL t660_left cyc %0d: got %h expected %h", i, audio_left, m_exp[0]); end
            if (i == 34) begin
                checks++;
                if (dut.u_left.half_period !== 32'd75757) begin failures++; $display("FAIL t660_hp: got %0d expected 75757", dut.u_left.half_period); end
            end
            if (i == 35) begin
                checks++;
                if (audio_left !== 16'hC000) begin failures++; $display("FAIL t660_phase0: got %h expected c000", audio_left); end
            end
        end
    endtask

    task automatic test_mid_divide();
        toneL = 32'd262;
        for (int i = 1; i <= 110; i++) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL middiv_left cyc %0d: got %h expected %h", i, audio_left, m_exp[0]); end
            if (i == 10) toneL = 32'd392;
            if (i == 50) toneL = 32'd524;
            if (i == 33 || i == 34 || i == 67 || i == 68 || i == 101 || i == 102) begin
                logic [31:0] want;
                case (i)
                    33:      want = 32'd75757;
                    34, 67:  want = 32'd190839;
                    68, 101: want = 32'd127551;
                    default: want = 32'd95419;
                endcase
                checks++;
                if (dut.u_left.half_period !== want) begin failures++; $display("FAIL middiv_hp cyc %0d: got %0d expected %0d", i, dut.u_left.half_period, want); end
            end
        end
    endtask

    task automatic test_en_toggle();
        toneL = 32'd12_500; toneR = 32'd10_000; volume = 3'd5;
        repeat (4540) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL en_run_left: got %h expected %h", audio_left, m_exp[0]); end
            checks++;
            if (audio_right !== exp_right()) begin failures++; $display("FAIL en_run_right: got %h expected %h", audio_right, exp_right()); end
        end
        en = 1'b0;
        tick();
        checks++;
        if (audio_left !== 16'd0) begin failures++; $display("FAIL en_low_left: got %h expected 0000", audio_left); end
        checks++;
        if (audio_right !== 16'd0) begin failures++; $display("FAIL en_low_right: got %h expected 0000", audio_right); end
        repeat (10) tick();
        en = 1'b1;
        for (int t = 1; t <= 9000; t++) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL en_rise_left cyc %0d: got %h expected %h", t, audio_left, m_exp[0]); end
            checks++;
            if (audio_right !== exp_right()) begin failures++; $display("FAIL en_rise_right cyc %0d: got %h expected %h", t, audio_right, exp_right()); end
            if (t == 1 || t == 4000 || t == 4001) begin
                logic [15:0] want;
                want = (t == 4001) ? 16'h4000 : 16'hC000;
                checks++;
                if (audio_left !== want) begin failures++; $display("FAIL en_restart cyc %0d: got %h expected %h", t, audio_left, want); end
            end
        end
        checks++;
        if (dut.u_left.half_period !== 32'd4000) begin failures++; $display("FAIL en_hp_kept: got %0d expected 4000", dut.u_left.half_period); end
    endtask

    function automatic logic [31:0] rand_tone();
        int pick;
        pick = $urandom_range(0, 9);
        if (pick == 0) begin
            case ($urandom_range(0, 2))
                0:       return 32'd0;
                1:       return 32'd20_001;
                default: return 32'd50_000_000;
            endcase
        end
        if (pick == 1) return 32'd20_000;
        return 32'($urandom_range(5_000, 20_000));
    endfunction

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n;
            toneL  = rand_tone();
            toneR  = rand_tone();
            volume = 3'($urandom_range(0, 7));
            en     = ($urandom_range(0, 3) != 0);
            n      = $urandom_range(100, 6000);
            for (int c = 0; c < n; c++) begin
                tick();
                checks++;
                if (audio_left !== m_exp[0]) begin failures++; $display("FAIL rand_left it %0d cyc %0d: got %h expected %h", it, c, audio_left, m_exp[0]); end
                checks++;
                if (audio_right !== exp_right()) begin failures++; $display("FAIL rand_right it %0d cyc %0d: got %h expected %h", it, c, audio_right, exp_right()); end
                if ($urandom_range(0, 499) == 0) volume = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 999) == 0) en = ~en;
                if ($urandom_range(0, 1499) == 0) toneL = rand_tone();
            end
        end
    endtask

    task automatic test_reset_mid_divide();
        en = 1'b1; volume = 3'd4; toneL = 32'd8_000; toneR = 32'd16_000;
        repeat (60) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL prerst_left: got %h expected %h", audio_left, m_exp[0]); end
        end
        toneL = 32'd9_000;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (audio_left !== 16'd0) begin failures++; $display("FAIL rst_mid_left: got %h expected 0000", audio_left); end
        checks++;
        if (audio_right !== 16'd0) begin failures++; $display("FAIL rst_mid_right: got %h expected 0000", audio_right); end
        checks++;
        if (dut.u_left.half_period !== 32'd0) begin failures++; $display("FAIL rst_mid_hp: got %0d expected 0", dut.u_left.half_period); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            checks++;
            if (audio_left !== m_exp[0]) begin failures++; $display("FAIL postrst_left cyc %0d: got %h expected %h", i, audio_left, m_exp[0]); end
            if (i == 34) begin
                checks++;
                if (dut.u_left.half_period !== 32'd5555) begin failures++; $display("FAIL postrst_hp: got %0d expected 5555", dut.u_left.half_period); end
            end
        end
    endtask

`ifdef NOTE_GEN_MONO_EN
    task automatic test_mono();
        en = 1'b1; volume = 3'd2; toneL = 32'd494; toneR = 32'd784;
        for (int i = 1; i <= 60; i++) begin
            tick();
            checks++;
            if (audio_right !== audio_left) begin failures++; $display("FAIL mono_mirror cyc %0d: got %h expected %h", i, audio_right, audio_left); end
            if (i == 34) begin
                checks++;
                if (dut.u_left.half_period !== 32'd101214) begin failures++; $display("FAIL mono_hp: got %0d expected 101214", dut.u_left.half_period); end
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_tone_988();
        test_volume_sat();
        test_silence();
        test_mid_divide();
        test_en_toggle();
        test_random();
        test_reset_mid_divide();
`ifdef NOTE_GEN_MONO_EN
        test_mono();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
